// File: rtl/regression_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the time-multiplexed regression sequencer.
package regression_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int N_FEAT_DEF = 3;
  localparam int FW_DEF     = 16;
  localparam int AW_DEF     = 32;

  // Width that holds 0..n_feat; used for both the beat counter and cfg_addr.
  function automatic int cnt_w(input int n_feat);
    return (n_feat < 1) ? 1 : $clog2(n_feat + 1);
  endfunction

endpackage

// File: rtl/regression_seq_ctrl_if.sv
// Config port, feature stream and result stream of the regression sequencer.
interface regression_seq_ctrl_if
  import regression_seq_ctrl_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int FW     = FW_DEF,
  parameter int AW     = AW_DEF
) ();

  localparam int ADDR_W = cnt_w(N_FEAT);

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [AW-1:0]     cfg_data;
  logic              cfg_err;

  logic              feat_valid;
  logic              feat_ready;
  logic [FW-1:0]     feat_data;

  logic              y_valid;
  logic              y_ready;
  logic [AW-1:0]     y;
  logic              y_ovf;

  modport master (
    output cfg_we, cfg_addr, cfg_data, feat_valid, feat_data, y_ready,
    input  cfg_err, feat_ready, y_valid, y, y_ovf
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, feat_valid, feat_data, y_ready,
    output cfg_err, feat_ready, y_valid, y, y_ovf
  );

endinterface

// File: rtl/regression_seq_ctrl_mac_unit.sv
// The single shared multiply-accumulate: {carry, sum} = acc_in + a*b.
module mac_unit #(
  parameter int FW = 16,
  parameter int AW = 32
) (
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  input  logic [AW-1:0] acc_in,
  output logic [AW-1:0] sum,
  output logic          carry
);

  logic [2*FW-1:0] prod;
  logic [AW:0]     total;

  // Product is zero-extended so the extra top bit of total is the true carry.
  assign prod  = a * b;
  assign total = {1'b0, acc_in} + (AW+1)'(prod);
  assign {carry, sum} = total;

endmodule

// File: rtl/regression_seq_ctrl.sv
// Sequencer: accumulates one feature per cycle through the shared MAC and
// presents y on a valid/ready port; owns the coefficient bank.
module regression_seq_ctrl
  import regression_seq_ctrl_pkg::*;
#(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int FW     = FW_DEF,
  parameter int AW     = AW_DEF
) (
  input logic            clk,
  input logic            rst,
  regression_seq_ctrl_if.slave bus
);

  localparam int CW = cnt_w(N_FEAT);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic          ovf;
  logic [AW-1:0] c0;
  logic [FW-1:0] coef [N_FEAT];

  logic          accept;
  logic          last_beat;
  logic          cfg_ok;
  logic [FW-1:0] coef_sel;
  logic [AW-1:0] mac_acc_in;
  logic [AW-1:0] mac_sum;
  logic          mac_carry;
  logic          ovf_nxt;

  assign accept     = bus.feat_valid && bus.feat_ready;
  assign last_beat  = (cnt == CW'(N_FEAT - 1));
  assign cfg_ok     = bus.cfg_we && (state == IDLE) && (bus.cfg_addr <= CW'(N_FEAT));
  assign mac_acc_in = (state == IDLE) ? c0 : acc;
  assign ovf_nxt    = (state == IDLE) ? mac_carry : (ovf | mac_carry);

  // Beat k always multiplies by c(k+1); cnt equals k when the beat arrives.
  always_comb begin
    coef_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (cnt == CW'(i)) coef_sel = coef[i];
    end
  end

  mac_unit #(.FW(FW), .AW(AW)) u_mac (
    .a      (coef_sel),
    .b      (bus.feat_data),
    .acc_in (mac_acc_in),
    .sum    (mac_sum),
    .carry  (mac_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (N_FEAT == 1) ? OUT : ACC;
      ACC:     if (accept && last_beat) state_nxt = OUT;
      OUT:     if (bus.y_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A config write in IDLE holds off the first beat so a sample never
  // mixes old and new coefficients.
  always_comb begin
    bus.feat_ready = 1'b0;
    bus.y_valid    = 1'b0;
    case (state)
      IDLE:    bus.feat_ready = !bus.cfg_we;
      ACC:     bus.feat_ready = 1'b1;
      OUT:     bus.y_valid    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      bus.y     <= '0;
      bus.y_ovf <= 1'b0;
    end else if (accept) begin
      acc <= mac_sum;
      ovf <= ovf_nxt;
      cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
      if (last_beat) begin
        bus.y     <= mac_sum;
        bus.y_ovf <= ovf_nxt;
      end
    end else if (state == OUT && bus.y_ready) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0          <= '0;
      bus.cfg_err <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) coef[i] <= '0;
    end else begin
      bus.cfg_err <= bus.cfg_we && !cfg_ok;
      if (cfg_ok) begin
        if (bus.cfg_addr == '0) c0 <= bus.cfg_data;
        for (int i = 0; i < N_FEAT; i++) begin
          if (bus.cfg_addr == CW'(i + 1)) coef[i] <= bus.cfg_data[FW-1:0];
        end
      end
    end
  end

endmodule
